if_fetch_stage: RTL
===================

// Module: if_fetch_stage
//
// PURPOSE
//   Instruction-fetch stage of the pipelined OTTER core, sitting directly upstream of the IF/ID register.
//   Owns the PC and drives the instruction-memory request/acknowledge port (one outstanding request).
//   Presents fetched instruction, PC and PC+4 as DOUT2_IF / ADDR_IF / N_ADDR_IF with a VALID_IF qualifier.
//   Honours STALL from the hazard unit and REDIRECT (branch/jump/trap target) from EX.
//
// PARAMETERS
//   RESET_ADDR  32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
//
// PORTS
//   CLK            in   1   clock; all state updates on posedge
//   RST            in   1   synchronous, active-high reset
//   STALL          in   1   downstream holds; output slot not consumed this cycle
//   REDIRECT       in   1   discard in-flight/held fetches, restart at REDIRECT_ADDR
//   REDIRECT_ADDR  in   32  new PC; bits [1:0] ignored (forced 00)
//   IMEM_REQ       out  1   fetch request
//   IMEM_ADDR      out  32  fetch address, word aligned
//   IMEM_ACK       in   1   memory accepts and returns data this cycle; same-cycle ACK legal
//   IMEM_RDATA     in   32  instruction word; valid only when IMEM_REQ && IMEM_ACK
//   DOUT2_IF       out  32  instruction to IF/ID
//   ADDR_IF        out  32  PC of DOUT2_IF
//   N_ADDR_IF      out  32  ADDR_IF + 4
//   VALID_IF       out  1   output slot holds an unconsumed instruction
//
// BEHAVIOUR
//   Reset: PC=RESET_ADDR; IMEM_REQ=0; IMEM_ADDR=0; DOUT2_IF=ADDR_IF=N_ADDR_IF=0; VALID_IF=0; state=S_IDLE; skid empty.
//   Reset mid-request: abandon the request without waiting for ACK; the memory side is reset together with this stage.
//   Consume: the output slot is consumed at a posedge with VALID_IF && !STALL. "Slot free" means !VALID_IF || !STALL.
//   Memory handshake:
//     - Once IMEM_REQ rises, IMEM_REQ and IMEM_ADDR hold stable until the ACK cycle.
//     - IMEM_ADDR and IMEM_REQ come straight from registers (no combinational path from STALL/ACK).
//   PC and IMEM_ADDR arithmetic: both 32-bit; PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0, no flag).
//   States:
//     S_IDLE   REQ=0. Slot free -> IMEM_ADDR<=PC, go S_REQ.
//     S_REQ    REQ=1 at IMEM_ADDR.
//              - ACK && slot free: output<={RDATA, IMEM_ADDR, IMEM_ADDR+4}, VALID_IF<=1, PC<=PC+4,
//                IMEM_ADDR<=PC+4, stay S_REQ. Sustains 1 instr/clk with zero-wait ACK.
//              - ACK && slot busy: capture into skid register, go S_HOLD.
//              - No ACK: stay.
//     S_HOLD   REQ=0. Slot free -> output<=skid, VALID_IF<=1, IMEM_ADDR<=PC, go S_REQ.
//     S_DRAIN  REQ=1 at the stale IMEM_ADDR. On ACK, discard RDATA, IMEM_ADDR<=PC, go S_REQ.
//   REDIRECT (highest priority, any state):
//     - Always: PC<=REDIRECT_ADDR&~3, VALID_IF<=0, skid cleared.
//     - S_IDLE, S_HOLD, or S_REQ with ACK same cycle: IMEM_ADDR<=new PC, go S_REQ; ACKed data discarded.
//     - S_REQ without ACK: go S_DRAIN.
//     - S_DRAIN: stay; only PC updates.
//   Latency: request cycle n with ACK -> VALID_IF/DOUT2_IF at n+1. Redirect at n -> new-target request at n+1,
//     or at the ACK+1 cycle if draining.
//   STALL && REDIRECT together: REDIRECT wins; the slot is flushed.
//   Outputs DOUT2_IF/ADDR_IF/N_ADDR_IF hold their value while VALID_IF && STALL. When VALID_IF=0 their value is don't-care.
//
// STRUCTURE
//   otter_pkg: typedef enum logic [1:0] {S_IDLE,S_REQ,S_HOLD,S_DRAIN} fetch_state_t; localparam XLEN=32; INSTR_ALIGN_MASK=32'hFFFF_FFFC.
//   Single module, no sub-modules; PC, IMEM_ADDR, skid {instr,addr} and output registers in one always_ff,
//     next-state logic in one always_comb.
//
// TESTING
//   1. RST high 3 clk, RESET_ADDR=0, ACK tied 1, STALL=0:
//      -> first REQ 1 clk after RST falls; ADDR_IF=0,4,8,... one per clk; N_ADDR_IF=ADDR_IF+4.
//   2. ACK after 3 wait cycles -> IMEM_ADDR stable across all wait cycles; VALID_IF only after each ACK; no REQ drop before ACK.
//   3. STALL high 4 clk while VALID_IF=1, ACK=1:
//      -> DOUT2_IF/ADDR_IF frozen; one extra instr lands in skid; REQ=0 in S_HOLD;
//         STALL low -> skid PC appears next clk with no gap or duplicate.
//   4. REDIRECT to 32'h0000_0103 while REQ pending unACKed:
//      -> VALID_IF=0 next clk; stale ACK data never appears on DOUT2_IF; next REQ at 32'h0000_0100.
//   5. REDIRECT same cycle as ACK, and REDIRECT+STALL together -> fetched word dropped, VALID_IF=0, next ADDR_IF=target.
//   6. PC=32'hFFFF_FFFC fetched -> N_ADDR_IF=0, next IMEM_ADDR=0; RST asserted while in S_DRAIN -> all outputs at reset values next clk.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER pipelined core front end.
package otter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_stage.sv
// OTTER instruction-fetch stage: owns the PC, runs a single-outstanding imem handshake,
// and feeds the IF/ID register through a one-entry output slot backed by a skid register.
module if_fetch_stage
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL,
    input  logic            REDIRECT,
    input  logic [XLEN-1:0] REDIRECT_ADDR,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    input  logic            IMEM_ACK,
    input  logic [XLEN-1:0] IMEM_RDATA,
    output logic [XLEN-1:0] DOUT2_IF,
    output logic [XLEN-1:0] ADDR_IF,
    output logic [XLEN-1:0] N_ADDR_IF,
    output logic            VALID_IF
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_addr_q, skid_addr_d;
    logic [XLEN-1:0] dout_q, dout_d;
    logic [XLEN-1:0] addr_if_q, addr_if_d;
    logic [XLEN-1:0] n_addr_if_q, n_addr_if_d;
    logic            valid_q, valid_d;

    logic            slot_free;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] pc_plus4;

    assign slot_free   = !valid_q || !STALL;
    assign redirect_pc = REDIRECT_ADDR & INSTR_ALIGN_MASK;
    assign pc_plus4    = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        imem_addr_d  = imem_addr_q;
        skid_instr_d = skid_instr_q;
        skid_addr_d  = skid_addr_q;
        dout_d       = dout_q;
        addr_if_d    = addr_if_q;
        n_addr_if_d  = n_addr_if_q;
        // A consumed slot empties unless a new word is loaded below.
        valid_d      = valid_q && STALL;

        if (REDIRECT) begin
            pc_d         = redirect_pc;
            valid_d      = 1'b0;
            skid_instr_d = '0;
            skid_addr_d  = '0;
            case (state_q)
                S_REQ: begin
                    if (IMEM_ACK) begin
                        imem_addr_d = redirect_pc;
                        state_d     = S_REQ;
                    end else begin
                        // Request already issued must complete before the new target goes out.
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: state_d = S_DRAIN;
                default: begin
                    imem_addr_d = redirect_pc;
                    state_d     = S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (slot_free) begin
                        imem_addr_d = pc_q;
                        state_d     = S_REQ;
                    end
                end
                S_REQ: begin
                    if (IMEM_ACK) begin
                        pc_d = pc_plus4;
                        if (slot_free) begin
                            dout_d      = IMEM_RDATA;
                            addr_if_d   = imem_addr_q;
                            n_addr_if_d = imem_addr_q + 32'd4;
                            valid_d     = 1'b1;
                            imem_addr_d = pc_plus4;
                        end else begin
                            skid_instr_d = IMEM_RDATA;
                            skid_addr_d  = imem_addr_q;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        dout_d      = skid_instr_q;
                        addr_if_d   = skid_addr_q;
                        n_addr_if_d = skid_addr_q + 32'd4;
                        valid_d     = 1'b1;
                        imem_addr_d = pc_q;
                        state_d     = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (IMEM_ACK) begin
                        imem_addr_d = pc_q;
                        state_d     = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        req_d = (state_d == S_REQ) || (state_d == S_DRAIN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_ADDR & INSTR_ALIGN_MASK;
            imem_addr_q  <= '0;
            req_q        <= 1'b0;
            skid_instr_q <= '0;
            skid_addr_q  <= '0;
            dout_q       <= '0;
            addr_if_q    <= '0;
            n_addr_if_q  <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_addr_q  <= imem_addr_d;
            req_q        <= req_d;
            skid_instr_q <= skid_instr_d;
            skid_addr_q  <= skid_addr_d;
            dout_q       <= dout_d;
            addr_if_q    <= addr_if_d;
            n_addr_if_q  <= n_addr_if_d;
            valid_q      <= valid_d;
        end
    end

    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = imem_addr_q;
    assign DOUT2_IF  = dout_q;
    assign ADDR_IF   = addr_if_q;
    assign N_ADDR_IF = n_addr_if_q;
    assign VALID_IF  = valid_q;

endmodule
